// File: rtl/serial_byte_collector.sv
// serial_byte_collector: framed serial-in / parallel-out word assembler.
// Collects DATA_W bits per frame (frame opened by sof), publishes the word on
// o_byte_out with a one-cycle o_load pulse, and flags inter-bit timeouts and
// sof-restarts on o_frame_err.
// Optional macro SBC_PARITY_CHECK_EN: each frame carries a trailing even-parity
// bit, checked before the word is published (mismatch pulses o_parity_err).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for sdata_valid && sof
// ST_SHIFT | collecting data bits, gap counter running
// ST_PARITY| all data bits held, waiting for the parity bit (macro only)
module serial_byte_collector #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic              i_clk,
    input  logic              i_sync_rst_n,
    input  logic              i_sdata,
    input  logic              i_sdata_valid,
    input  logic              i_sof,
    output logic [DATA_W-1:0] o_byte_out,
    output logic              o_load,
    output logic              o_busy,
    output logic              o_frame_err,
    output logic              o_parity_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
`ifdef SBC_PARITY_CHECK_EN
        , ST_PARITY = 2'd2
`endif
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [DATA_W-1:0] r_byte_out;
    logic              r_load;
    logic              r_busy;
    logic              r_frame_err;

    state_t            w_state_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]  w_bit_cnt_nxt;
    logic [GAP_W-1:0]  w_gap_cnt_nxt;
    logic [DATA_W-1:0] w_byte_nxt;
    logic              w_load_nxt;
    logic              w_ferr_nxt;

    logic [DATA_W-1:0] w_first_word;
    logic [DATA_W-1:0] w_shifted;

`ifdef SBC_PARITY_CHECK_EN
    logic              r_parity_err;
    logic              w_perr_nxt;
`endif

    // Bit order: the first bit must end up at the MSB (shift left) or LSB (shift right).
    if (MSB_FIRST != 0) begin : g_msb_first
        assign w_first_word = {{(DATA_W-1){1'b0}}, i_sdata};
        assign w_shifted    = {r_shift[DATA_W-2:0], i_sdata};
    end else begin : g_lsb_first
        assign w_first_word = {i_sdata, {(DATA_W-1){1'b0}}};
        assign w_shifted    = {i_sdata, r_shift[DATA_W-1:1]};
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_byte_nxt    = r_byte_out;
        w_load_nxt    = 1'b0;
        w_ferr_nxt    = 1'b0;
`ifdef SBC_PARITY_CHECK_EN
        w_perr_nxt    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (i_sdata_valid && i_sof) begin
                    w_shift_nxt   = w_first_word;
                    w_bit_cnt_nxt = CNT_W'(1);
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (i_sdata_valid && i_sof) begin
                    w_ferr_nxt    = 1'b1;
                    w_shift_nxt   = w_first_word;
                    w_bit_cnt_nxt = CNT_W'(1);
                    w_gap_cnt_nxt = '0;
                end else if (i_sdata_valid) begin
                    w_gap_cnt_nxt = '0;
                    w_shift_nxt   = w_shifted;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_bit_cnt_nxt = '0;
`ifdef SBC_PARITY_CHECK_EN
                        w_state_nxt   = ST_PARITY;
`else
                        w_byte_nxt    = w_shifted;
                        w_load_nxt    = 1'b1;
                        w_state_nxt   = ST_IDLE;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_ferr_nxt    = 1'b1;
                    w_shift_nxt   = '0;
                    w_bit_cnt_nxt = '0;
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
`ifdef SBC_PARITY_CHECK_EN
            ST_PARITY: begin
                if (i_sdata_valid && i_sof) begin
                    w_ferr_nxt    = 1'b1;
                    w_shift_nxt   = w_first_word;
                    w_bit_cnt_nxt = CNT_W'(1);
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = ST_SHIFT;
                end else if (i_sdata_valid) begin
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = ST_IDLE;
                    // Even parity: the parity bit equals the XOR of the data bits.
                    if ((^r_shift) == i_sdata) begin
                        w_byte_nxt = r_shift;
                        w_load_nxt = 1'b1;
                    end else begin
                        w_perr_nxt = 1'b1;
                    end
                end else if (r_gap_cnt == GAP_LAST) begin
                    w_ferr_nxt    = 1'b1;
                    w_shift_nxt   = '0;
                    w_gap_cnt_nxt = '0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_sync_rst_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_byte_out   <= '0;
            r_load       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef SBC_PARITY_CHECK_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_byte_out   <= w_byte_nxt;
            r_load       <= w_load_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_frame_err  <= w_ferr_nxt;
`ifdef SBC_PARITY_CHECK_EN
            r_parity_err <= w_perr_nxt;
`endif
        end
    end

    assign o_byte_out  = r_byte_out;
    assign o_load      = r_load;
    assign o_busy      = r_busy;
    assign o_frame_err = r_frame_err;
`ifdef SBC_PARITY_CHECK_EN
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_collector.sv
// Bench for serial_byte_collector: one MSB-first and one LSB-first instance
// share the serial inputs; a bit-queue model predicts every output per cycle.
module tb_serial_byte_collector;

    localparam int DW = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sdata = 1'b0;
    logic          sv = 1'b0;
    logic          sof = 1'b0;
    logic [DW-1:0] byte_a, byte_b;
    logic          load_a, busy_a, ferr_a, perr_a;
    logic          load_b, busy_b, ferr_b, perr_b;

    always #5 clk = ~clk;

    serial_byte_collector #(.DATA_W(DW), .MSB_FIRST(1), .TIMEOUT(TO)) dut_a (
        .i_clk(clk), .i_sync_rst_n(rst_n), .i_sdata(sdata), .i_sdata_valid(sv),
        .i_sof(sof), .o_byte_out(byte_a), .o_load(load_a), .o_busy(busy_a),
        .o_frame_err(ferr_a), .o_parity_err(perr_a));

    serial_byte_collector #(.DATA_W(DW), .MSB_FIRST(0), .TIMEOUT(TO)) dut_b (
        .i_clk(clk), .i_sync_rst_n(rst_n), .i_sdata(sdata), .i_sdata_valid(sv),
        .i_sof(sof), .o_byte_out(byte_b), .o_load(load_b), .o_busy(busy_b),
        .o_frame_err(ferr_b), .o_parity_err(perr_b));

    int total = 0;
    int bad   = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            q[$];
    bit            in_frame = 0;
    bit            want_par = 0;
    int            gap = 0;
    bit            armed = 0;
    logic [DW-1:0] e_byte_a = '0, e_byte_b = '0;
    logic          e_load = 0, e_busy = 0, e_ferr = 0, e_perr = 0;

    function automatic logic [DW-1:0] pack(input bit first_is_msb);
        logic [DW-1:0] w = '0;
        for (int i = 0; i < q.size(); i++) begin
            if (first_is_msb) w[DW-1-i] = q[i];
            else              w[i] = q[i];
        end
        return w;
    endfunction

    task automatic publish();
        e_byte_a = pack(1'b1);
        e_byte_b = pack(1'b0);
        e_load   = 1'b1;
    endtask

    always @(posedge clk) begin
        e_load = 0; e_ferr = 0; e_perr = 0;
        if (!rst_n) begin
            q.delete(); in_frame = 0; want_par = 0; gap = 0;
            e_byte_a = '0; e_byte_b = '0;
        end else if (sv && sof) begin
            if (in_frame) e_ferr = 1;
            q.delete(); q.push_back(sdata);
            in_frame = 1; want_par = 0; gap = 0;
        end else if (sv && in_frame) begin
            gap = 0;
            if (want_par) begin
                in_frame = 0; want_par = 0;
                if ((^pack(1'b1)) == sdata) publish();
                else e_perr = 1;
            end else begin
                q.push_back(sdata);
                if (q.size() == DW) begin
`ifdef SBC_PARITY_CHECK_EN
                    want_par = 1;
`else
                    publish();
                    in_frame = 0;
`endif
                end
            end
        end else if (!sv && in_frame) begin
            gap++;
            if (gap == TO) begin
                e_ferr = 1; in_frame = 0; want_par = 0; gap = 0;
            end
        end
        e_busy = in_frame;
        armed = 1;
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (armed) begin
            cmp("byte_a", 32'(byte_a), 32'(e_byte_a));
            cmp("byte_b", 32'(byte_b), 32'(e_byte_b));
            cmp("load_a", 32'(load_a), 32'(e_load));
            cmp("load_b", 32'(load_b), 32'(e_load));
            cmp("busy_a", 32'(busy_a), 32'(e_busy));
            cmp("busy_b", 32'(busy_b), 32'(e_busy));
            cmp("ferr_a", 32'(ferr_a), 32'(e_ferr));
            cmp("ferr_b", 32'(ferr_b), 32'(e_ferr));
            cmp("perr_a", 32'(perr_a), 32'(e_perr));
            cmp("perr_b", 32'(perr_b), 32'(e_perr));
        end
    end

    // Pulse counters for the directed literal checks.
    int cnt_load = 0, cnt_ferr = 0, cnt_perr = 0;
    always @(negedge clk) begin
        if (load_a === 1'b1) cnt_load++;
        if (ferr_a === 1'b1) cnt_ferr++;
        if (perr_a === 1'b1) cnt_perr++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic b, input logic v, input logic s);
        @(negedge clk);
        sdata = b; sv = v; sof = s;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input bit msb_order);
        for (int i = 0; i < DW; i++)
            tick(msb_order ? w[DW-1-i] : w[i], 1'b1, i == 0);
`ifdef SBC_PARITY_CHECK_EN
        tick(^w, 1'b1, 1'b0);
`endif
    endtask

    int l0, f0, p0;
    logic [DW-1:0] tmp;

    initial begin
        rst_n = 1'b0;
        repeat (3) tick(0, 0, 0);
        cmp("rst_byte", 32'(byte_a), 32'h0);
        cmp("rst_load", 32'(load_a), 32'h0);
        cmp("rst_busy", 32'(busy_a), 32'h0);
        cmp("rst_ferr", 32'(ferr_a), 32'h0);
        rst_n = 1'b1;

        // 0xAA MSB-first
        send_word(8'hAA, 1'b1);
        tick(0, 0, 0);
        cmp("aa_load", 32'(load_a), 32'h1);
        cmp("aa_byte", 32'(byte_a), 32'hAA);
        cmp("aa_busy", 32'(busy_a), 32'h0);
        cmp("aa_ferr", 32'(ferr_a), 32'h0);
        tick(0, 0, 0);
        cmp("aa_load_once", 32'(load_a), 32'h0);

        // 0x55 then 0xFF back to back, sof of 0xFF in the load cycle
        #1 l0 = cnt_load;
        send_word(8'h55, 1'b1);
        tick(1, 1, 1);
        cmp("b2b_load55", 32'(load_a), 32'h1);
        cmp("b2b_byte55", 32'(byte_a), 32'h55);
        repeat (DW - 1) tick(1, 1, 0);
`ifdef SBC_PARITY_CHECK_EN
        tick(0, 1, 0);
`endif
        tick(0, 0, 0);
        cmp("b2b_byteFF", 32'(byte_a), 32'hFF);
        tick(0, 0, 0);
        #1 cmp("b2b_loads", 32'(cnt_load - l0), 32'd2);

        // 3 bits then a full timeout
        f0 = cnt_ferr; l0 = cnt_load;
        tick(1, 1, 1); tick(0, 1, 0); tick(1, 1, 0);
        repeat (TO + 3) tick(0, 0, 0);
        #1;
        cmp("to_ferr", 32'(cnt_ferr - f0), 32'd1);
        cmp("to_load", 32'(cnt_load - l0), 32'd0);
        cmp("to_byte", 32'(byte_a), 32'hFF);
        cmp("to_busy", 32'(busy_a), 32'h0);

        // one idle cycle short of the timeout: frame survives -> 0xDA
        f0 = cnt_ferr;
        tmp = 8'h5A;
        tick(1, 1, 1);
        repeat (TO - 1) tick(0, 0, 0);
        for (int i = DW - 2; i >= 0; i--) tick(tmp[i], 1, 0);
`ifdef SBC_PARITY_CHECK_EN
        tick(1'b1 ^ (^tmp[DW-2:0]), 1, 0);
`endif
        tick(0, 0, 0);
        cmp("gap14_load", 32'(load_a), 32'h1);
        cmp("gap14_byte_a", 32'(byte_a), 32'hDA);
        cmp("gap14_byte_b", 32'(byte_b), 32'h5B);
        #1 cmp("gap14_ferr", 32'(cnt_ferr - f0), 32'd0);

        // 4 bits, then restart with 0x3C
        f0 = cnt_ferr; l0 = cnt_load;
        tick(1, 1, 1); repeat (3) tick(1, 1, 0);
        send_word(8'h3C, 1'b1);
        tick(0, 0, 0);
        cmp("rs_byte", 32'(byte_a), 32'h3C);
        tick(0, 0, 0);
        #1;
        cmp("rs_ferr", 32'(cnt_ferr - f0), 32'd1);
        cmp("rs_load", 32'(cnt_load - l0), 32'd1);

        // reset after 5 bits, then 0x81
        tick(1, 1, 1); repeat (4) tick(0, 1, 0);
        @(negedge clk); rst_n = 1'b0; sv = 0; sof = 0;
        tick(0, 0, 0);
        rst_n = 1'b1;
        cmp("mr_byte", 32'(byte_a), 32'h0);
        cmp("mr_busy", 32'(busy_a), 32'h0);
        cmp("mr_ferr", 32'(ferr_a), 32'h0);
        cmp("mr_load", 32'(load_a), 32'h0);
        send_word(8'h81, 1'b1);
        tick(0, 0, 0);
        cmp("r81_load", 32'(load_a), 32'h1);
        cmp("r81_byte", 32'(byte_a), 32'h81);

        // bits 1,0,0,0,0,0,0,0: LSB-first instance sees 0x01
        send_word(8'h01, 1'b0);
        tick(0, 0, 0);
        cmp("lsb_byte_b", 32'(byte_b), 32'h01);
        cmp("lsb_byte_a", 32'(byte_a), 32'h80);

`ifdef SBC_PARITY_CHECK_EN
        // 0xAA with wrong parity bit
        p0 = cnt_perr; l0 = cnt_load;
        for (int i = DW - 1; i >= 0; i--) tick(i[0] ? 1'b1 : 1'b0, 1, i == DW - 1);
        tick(1, 1, 0);
        repeat (2) tick(0, 0, 0);
        #1;
        cmp("par_err", 32'(cnt_perr - p0), 32'd1);
        cmp("par_noload", 32'(cnt_load - l0), 32'd0);
`else
        p0 = cnt_perr;
        #1 cmp("par_tied", 32'(cnt_perr - p0), 32'd0);
`endif

        // randomized traffic with idle bursts, stray sof and rare resets
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                repeat ($urandom_range(TO - 3, TO + 3)) tick(0, 0, $urandom_range(0, 1));
            end else begin
                @(negedge clk);
                sv    = ($urandom_range(0, 99) < 70);
                sof   = ($urandom_range(0, 99) < (sv ? 8 : 20));
                sdata = $urandom_range(0, 1);
                rst_n = ($urandom_range(0, 999) >= 2);
            end
        end
        tick(0, 0, 0);
        rst_n = 1'b1;
        repeat (3) tick(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_byte_collector.md
Name: serial_byte_collector

Overview:
- Serial-in / parallel-out front end that sits directly upstream of the 8-bit load register.
- Assembles framed serial bits into a DATA_W-bit word.
- Presents the word on byte_out with a one-cycle load pulse that drives the register's load/data_in pair.
- Detects inter-bit timeout and aborted frames, and reports them on frame_err.

Parameters:
- DATA_W, 8, bits per frame (2..32).
- MSB_FIRST, 1, 1 = first serial bit lands in byte_out[DATA_W-1]; 0 = first bit lands in byte_out[0].
- TIMEOUT, 15, consecutive idle cycles inside a frame that abort it (>=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- sync_rst_n  input  1  synchronous reset, active low.
- sdata  input  1  serial data bit.
- sdata_valid  input  1  sdata is valid this cycle.
- sof  input  1  start of frame; qualified by sdata_valid; marks the first bit.
- byte_out  output  DATA_W  last completed word; held between completions.
- load  output  1  one-cycle pulse: byte_out is newly valid (connects to downstream load).
- busy  output  1  high while in SHIFT or PARITY.
- frame_err  output  1  one-cycle pulse on an aborted frame.
- parity_err  output  1  one-cycle pulse on parity mismatch (see Optional Feature).

Behaviour:
- Interface: one clock, clk. Reset sync_rst_n is synchronous and active-low.
- Reset (sync_rst_n=0 at a clk edge):
  - state=IDLE; shift register, bit_cnt and gap_cnt = 0.
  - byte_out=0, load=0, busy=0, frame_err=0, parity_err=0.
  - Reset mid-frame discards the partial word; no load and no err pulse.
- States: IDLE, SHIFT, PARITY (PARITY only with the macro).
- IDLE:
  - sdata_valid&&sof captures sdata as bit 0, sets bit_cnt=1, moves to SHIFT.
  - sdata_valid without sof is ignored.
  - If DATA_W bits are captured by one transfer (DATA_W=1 not allowed), that is not applicable.
- SHIFT, on each sdata_valid:
  - Shift in sdata, bit_cnt++, gap_cnt=0.
  - MSB_FIRST=1: shift left, new bit at LSB. MSB_FIRST=0: shift right, new bit at MSB.
- Completion, on the edge accepting bit DATA_W:
  - Assembled word goes to byte_out and load=1 for exactly that next cycle.
  - State goes to IDLE (or PARITY with the macro).
  - Latency: load is high in the cycle immediately after the last bit's accept edge.
- Back-to-back frames: sof+sdata_valid in the cycle where load=1 is accepted as bit 0 of a new frame. No dead cycle.
- Gap timeout:
  - In SHIFT, each cycle without sdata_valid increments gap_cnt.
  - When TIMEOUT consecutive idle cycles elapse, frame_err=1 for one cycle, state=IDLE, partial word dropped.
  - byte_out unchanged and load stays 0.
- Restart: sdata_valid&&sof while in SHIFT:
  - frame_err pulses in the next cycle (the old frame is aborted).
  - The current bit is captured as bit 0 of a new frame (bit_cnt=1). State stays SHIFT.
- sof without sdata_valid has no effect in any state.
- busy is registered: 1 in the cycle after entering SHIFT until the cycle state returns to IDLE.
- Widths and outputs:
  - bit_cnt is clog2(DATA_W+1) bits; gap_cnt is clog2(TIMEOUT+1) bits.
  - No wrap-around: bit_cnt is cleared on completion or abort.
  - All outputs are registered; no combinational input-to-output path.

Optional Feature:
- Macro: SBC_PARITY_CHECK_EN.
- When defined:
  - After bit DATA_W, the FSM enters PARITY and the word is not yet published.
  - The next sdata_valid bit is an even-parity bit over the data bits.
  - Match: byte_out updated and load pulses next cycle.
  - Mismatch: parity_err pulses, byte_out held, no load.
  - Timeout and sof-restart rules apply in PARITY exactly as in SHIFT.
- When undefined:
  - No PARITY state; completion as above.
  - parity_err tied to 0.

Test Plan:
- Reset 3 cycles, then feed 0xAA MSB-first (1,0,1,0,1,0,1,0) with sof on the first bit, valid every cycle -> load=1 for exactly the one cycle after the 8th bit, byte_out=0xAA, busy falls with it, frame_err=0.
- Frame 0x55 immediately followed (sof in the load cycle) by frame 0xFF -> two single-cycle load pulses 8 cycles apart, byte_out=0x55 then 0xFF.
- After 0xAA completes, send sof + 3 bits, then 15 idle cycles -> frame_err pulses once, load stays 0, byte_out stays 0xAA, busy=0.
- Send sof + 4 bits, then sof with the bits of 0x3C -> one frame_err pulse, then load with byte_out=0x3C.
- Pull sync_rst_n low after 5 bits of a frame -> all outputs 0 next cycle. A fresh 0x81 frame then completes normally with load=1, byte_out=0x81.
- MSB_FIRST=0 build, bits 1,0,0,0,0,0,0,0 -> byte_out=0x01. With SBC_PARITY_CHECK_EN defined, 0xAA + parity 0 -> load; 0xAA + parity 1 -> parity_err pulse, no load.
